video_timcfg: RTL and testbench
===============================

# video_timcfg

Mode controller for the video timing generator. It holds a staging bank of the eight horizontal and vertical timing settings, written over a simple register port, and validates that bank on request. It then swaps the staging bank into the active bank that drives the generator, but only on a frame boundary, so a mode change never produces a torn frame. It also sequences generator start and stop (clock enable and held reset) so the generator always starts from line 0, pixel 0 and always stops after a complete frame.

## Interface
Parameters: none; all widths match the timing generator settings.

- clk  in  1  pixel-domain clock; same clock as the timing generator
- rst  in  1  asynchronous, active-high reset
- pix_ena  in  1  pixel clock enable; forwarded to the generator while running
- cfg_we  in  1  staging register write strobe
- cfg_addr  in  3  0 Thsync, 1 Thgdel, 2 Thgate, 3 Thlen, 4 Tvsync, 5 Tvgdel, 6 Tvgate, 7 Tvlen
- cfg_wdata  in  16  write data; 8-bit registers take bits [7:0]
- cmd_commit  in  1  pulse: validate staging bank and schedule its load
- cmd_start  in  1  pulse: start the generator
- cmd_stop  in  1  pulse: stop the generator at the next frame boundary
- tg_eof  in  1  end-of-frame from the generator
- Thsync, Thgdel, Tvsync, Tvgdel  out  8 each  active settings to the generator
- Thgate, Thlen, Tvgate, Tvlen  out  16 each  active settings to the generator
- tg_clk_ena  out  1  generator clock enable
- tg_rst_n  out  1  generator reset (active low), driven from a register
- busy  out  1  a commit or stop is pending
- running  out  1  the generator is enabled
- cfg_done  out  1  one-cycle pulse when the active bank is loaded
- cfg_err  out  1  one-cycle pulse when a commit or start is rejected

## Operation
- **Frame boundary (fb)** = tg_eof & pix_ena & tg_rst_n.
- **Validation** of a bank, per axis:
  - Sync + Gdel + Gate is computed 17-bit and must be < Len.
  - Gate must be != 0.
  - The bank is valid only when both axes pass.
  - Validation is combinational on the staging bank.
- **act_valid flag**: set when a valid bank is loaded into the active bank; cleared only by rst.
- **Staging writes**: accepted in every state except PEND; cfg_we in PEND is ignored.
- **State STOP**:
  - tg_rst_n=0, tg_clk_ena=0, running=0.
  - cmd_commit: if valid, load active next edge, pulse cfg_done, stay in STOP; else pulse cfg_err.
  - cmd_start: if act_valid, go to RUN; else pulse cfg_err.
- **State RUN**:
  - tg_rst_n=1, tg_clk_ena=pix_ena, running=1.
  - cmd_commit valid -> PEND. cmd_commit invalid -> cfg_err, stay in RUN.
  - cmd_stop -> DRAIN.
  - cmd_commit (valid) with cmd_stop in the same cycle -> PEND with stop_req=1.
- **State PEND**:
  - Outputs as RUN; busy=1.
  - cmd_stop sets stop_req.
  - On fb: load active, pulse cfg_done, clear stop_req. Go to STOP if stop_req, else RUN.
- **State DRAIN**:
  - Outputs as RUN; busy=1.
  - cmd_commit -> cfg_err (ignored).
  - On fb -> STOP.
- **Command conflicts**:
  - cmd_start together with cmd_stop: stop wins; start is ignored.
  - cmd_start outside STOP is ignored.
- **Reset**:
  - Both banks 0, act_valid=0, stop_req=0, state STOP.
  - Outputs: tg_rst_n=0, tg_clk_ena=0, busy=0, running=0, cfg_done=0, cfg_err=0.
  - Mid-frame reset aborts immediately; no boundary wait.

## Timing
- Active registers update on the clock edge that samples fb. The generator's first cycle of the new frame therefore sees the new settings.
- A write to staging is visible to validation the cycle after cfg_we.
- cmd_start in STOP: tg_rst_n and tg_clk_ena rise one edge later.
- STOP entered from fb: tg_rst_n falls on that edge. The last-frame eof has already been sampled.
- cfg_done and cfg_err are registered and appear one cycle after the triggering event.
- No commands are queued. A second cmd_commit during PEND is ignored with no pulse.

## Test plan
- **Reset:** assert rst mid-stream -> all outputs 0 within the same cycle (async); after release, state STOP and running=0.
- **Start without a bank:** cmd_start before any commit -> cfg_err pulse, tg_clk_ena stays 0.
- **Valid bank, then start:**
  - Write Thsync=4, Thgdel=2, Thgate=16, Thlen=24, Tvsync=1, Tvgdel=1, Tvgate=4, Tvlen=8.
  - cmd_commit in STOP -> cfg_done next cycle, active outputs equal the written values.
  - cmd_start -> running=1 one edge later.
- **Invalid commit while running:** write Thlen=20 (4+2+16=22 ≥ 20) and commit -> cfg_err, active Thlen stays 24, state RUN.
- **Mid-frame change:** while running, write Thgate=12, Thlen=24 and commit mid-frame -> busy=1 until fb. Active Thgate changes exactly on the fb edge, cfg_done pulses, and writes during PEND are dropped.
- **Commit plus stop, and start/stop conflict:**
  - cmd_commit and cmd_stop in the same cycle -> new bank loaded at fb, then STOP, with tg_rst_n=0 after that edge.
  - cmd_start and cmd_stop together in STOP -> no start.

Source files
------------

// File: rtl/video_timcfg_if.sv
// Register/command port and timing-generator link of the video mode controller.
// The master modport is the host side; the slave modport is the controller.
interface video_timcfg_if;
   logic        pix_ena;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [15:0] cfg_wdata;
   logic        cmd_commit;
   logic        cmd_start;
   logic        cmd_stop;
   logic        tg_eof;
   logic [7:0]  Thsync;
   logic [7:0]  Thgdel;
   logic [15:0] Thgate;
   logic [15:0] Thlen;
   logic [7:0]  Tvsync;
   logic [7:0]  Tvgdel;
   logic [15:0] Tvgate;
   logic [15:0] Tvlen;
   logic        tg_clk_ena;
   logic        tg_rst_n;
   logic        busy;
   logic        running;
   logic        cfg_done;
   logic        cfg_err;

   modport master (
      output pix_ena, cfg_we, cfg_addr, cfg_wdata, cmd_commit, cmd_start, cmd_stop, tg_eof,
      input  Thsync, Thgdel, Thgate, Thlen, Tvsync, Tvgdel, Tvgate, Tvlen,
      input  tg_clk_ena, tg_rst_n, busy, running, cfg_done, cfg_err
   );

   modport slave (
      input  pix_ena, cfg_we, cfg_addr, cfg_wdata, cmd_commit, cmd_start, cmd_stop, tg_eof,
      output Thsync, Thgdel, Thgate, Thlen, Tvsync, Tvgdel, Tvgate, Tvlen,
      output tg_clk_ena, tg_rst_n, busy, running, cfg_done, cfg_err
   );
endinterface

// File: rtl/video_timcfg.sv
// Video timing mode controller: staging/active timing banks with frame-aligned swap,
// plus start/stop sequencing of the timing generator.
module video_timcfg (
   input logic           clk,
   input logic           rst,
   video_timcfg_if.slave bus
);

   typedef enum logic [1:0] {StStop, StRun, StPend, StDrain} state_e;

   state_e state_q, state_d;
   logic   stop_req_q, stop_req_d;
   logic   act_valid_q;
   logic   run_q, run_d;
   logic   done_q, done_d;
   logic   err_q, err_d;
   logic   load;
   logic   fb;
   logic   stg_we;

   logic [7:0]  stg_hsync_q, stg_hgdel_q, stg_vsync_q, stg_vgdel_q;
   logic [15:0] stg_hgate_q, stg_hlen_q, stg_vgate_q, stg_vlen_q;
   logic [7:0]  act_hsync_q, act_hgdel_q, act_vsync_q, act_vgdel_q;
   logic [15:0] act_hgate_q, act_hlen_q, act_vgate_q, act_vlen_q;

   logic [16:0] h_sum, v_sum;
   logic        h_ok, v_ok, bank_ok;

   // Sums are 17 bits wide so an overflowing Gate cannot wrap below Len.
   always_comb begin
      h_sum   = {9'd0, stg_hsync_q} + {9'd0, stg_hgdel_q} + {1'b0, stg_hgate_q};
      v_sum   = {9'd0, stg_vsync_q} + {9'd0, stg_vgdel_q} + {1'b0, stg_vgate_q};
      h_ok    = (h_sum < {1'b0, stg_hlen_q}) && (stg_hgate_q != 16'd0);
      v_ok    = (v_sum < {1'b0, stg_vlen_q}) && (stg_vgate_q != 16'd0);
      bank_ok = h_ok && v_ok;
   end

   // run_q doubles as the generator reset, so fb is only seen from a live generator.
   assign fb     = bus.tg_eof & bus.pix_ena & run_q;
   assign stg_we = bus.cfg_we && (state_q != StPend);

   always_comb begin
      state_d    = state_q;
      stop_req_d = stop_req_q;
      load       = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      unique case (state_q)
         StStop: begin
            if (bus.cmd_commit) begin
               if (bank_ok) begin
                  load   = 1'b1;
                  done_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            if (bus.cmd_start && !bus.cmd_stop) begin
               if (act_valid_q) state_d = StRun;
               else             err_d   = 1'b1;
            end
         end
         StRun: begin
            if (bus.cmd_commit && bank_ok) begin
               state_d    = StPend;
               stop_req_d = bus.cmd_stop;
            end else begin
               if (bus.cmd_commit) err_d = 1'b1;
               if (bus.cmd_stop) state_d = StDrain;
            end
         end
         StPend: begin
            if (bus.cmd_stop) stop_req_d = 1'b1;
            if (fb) begin
               load       = 1'b1;
               done_d     = 1'b1;
               stop_req_d = 1'b0;
               state_d    = (stop_req_q || bus.cmd_stop) ? StStop : StRun;
            end
         end
         StDrain: begin
            if (bus.cmd_commit) err_d = 1'b1;
            if (fb) state_d = StStop;
         end
         default: state_d = StStop;
      endcase
      run_d = (state_d != StStop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StStop;
         stop_req_q  <= 1'b0;
         act_valid_q <= 1'b0;
         run_q       <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         stop_req_q <= stop_req_d;
         run_q      <= run_d;
         done_q     <= done_d;
         err_q      <= err_d;
         if (load) act_valid_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stg_hsync_q <= '0;
         stg_hgdel_q <= '0;
         stg_hgate_q <= '0;
         stg_hlen_q  <= '0;
         stg_vsync_q <= '0;
         stg_vgdel_q <= '0;
         stg_vgate_q <= '0;
         stg_vlen_q  <= '0;
      end else if (stg_we) begin
         case (bus.cfg_addr)
            3'd0:    stg_hsync_q <= bus.cfg_wdata[7:0];
            3'd1:    stg_hgdel_q <= bus.cfg_wdata[7:0];
            3'd2:    stg_hgate_q <= bus.cfg_wdata;
            3'd3:    stg_hlen_q  <= bus.cfg_wdata;
            3'd4:    stg_vsync_q <= bus.cfg_wdata[7:0];
            3'd5:    stg_vgdel_q <= bus.cfg_wdata[7:0];
            3'd6:    stg_vgate_q <= bus.cfg_wdata;
            default: stg_vlen_q  <= bus.cfg_wdata;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_hsync_q <= '0;
         act_hgdel_q <= '0;
         act_hgate_q <= '0;
         act_hlen_q  <= '0;
         act_vsync_q <= '0;
         act_vgdel_q <= '0;
         act_vgate_q <= '0;
         act_vlen_q  <= '0;
      end else if (load) begin
         act_hsync_q <= stg_hsync_q;
         act_hgdel_q <= stg_hgdel_q;
         act_hgate_q <= stg_hgate_q;
         act_hlen_q  <= stg_hlen_q;
         act_vsync_q <= stg_vsync_q;
         act_vgdel_q <= stg_vgdel_q;
         act_vgate_q <= stg_vgate_q;
         act_vlen_q  <= stg_vlen_q;
      end
   end

   assign bus.Thsync     = act_hsync_q;
   assign bus.Thgdel     = act_hgdel_q;
   assign bus.Thgate     = act_hgate_q;
   assign bus.Thlen      = act_hlen_q;
   assign bus.Tvsync     = act_vsync_q;
   assign bus.Tvgdel     = act_vgdel_q;
   assign bus.Tvgate     = act_vgate_q;
   assign bus.Tvlen      = act_vlen_q;
   assign bus.tg_rst_n   = run_q;
   assign bus.tg_clk_ena = run_q & bus.pix_ena;
   assign bus.running    = run_q;
   assign bus.busy       = (state_q == StPend) || (state_q == StDrain);
   assign bus.cfg_done   = done_q;
   assign bus.cfg_err    = err_q;

endmodule

// File: tb/tb_video_timcfg.sv
// Directed bench for video_timcfg: bank validation, frame-aligned swap and start/stop.
module tb_video_timcfg;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   video_timcfg_if bus ();

   video_timcfg dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow directly.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] addr, input logic [15:0] data);
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = addr;
      bus.cfg_wdata = data;
      tick();
      bus.cfg_we    = 1'b0;
   endtask

   task automatic pulse(input logic commit, input logic start, input logic stop);
      bus.cmd_commit = commit;
      bus.cmd_start  = start;
      bus.cmd_stop   = stop;
      tick();
      bus.cmd_commit = 1'b0;
      bus.cmd_start  = 1'b0;
      bus.cmd_stop   = 1'b0;
   endtask

   task automatic eof();
      bus.tg_eof = 1'b1;
      tick();
      bus.tg_eof = 1'b0;
   endtask

   initial begin
      bus.pix_ena    = 1'b1;
      bus.cfg_we     = 1'b0;
      bus.cfg_addr   = 3'd0;
      bus.cfg_wdata  = 16'd0;
      bus.cmd_commit = 1'b0;
      bus.cmd_start  = 1'b0;
      bus.cmd_stop   = 1'b0;
      bus.tg_eof     = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("rst_running", {15'd0, bus.running}, 16'd0);
      check("rst_tg_rst_n", {15'd0, bus.tg_rst_n}, 16'd0);
      check("rst_busy", {15'd0, bus.busy}, 16'd0);
      check("rst_done", {15'd0, bus.cfg_done}, 16'd0);
      check("rst_thlen", bus.Thlen, 16'd0);

      // Start with no active bank is rejected.
      pulse(1'b0, 1'b1, 1'b0);
      check("nobank_err", {15'd0, bus.cfg_err}, 16'd1);
      check("nobank_clk_ena", {15'd0, bus.tg_clk_ena}, 16'd0);
      tick();
      check("nobank_err_clr", {15'd0, bus.cfg_err}, 16'd0);
      check("nobank_running", {15'd0, bus.running}, 16'd0);

      // Load a valid bank in STOP.
      wr(3'd0, 16'd4);
      wr(3'd1, 16'd2);
      wr(3'd2, 16'd16);
      wr(3'd3, 16'd24);
      wr(3'd4, 16'd1);
      wr(3'd5, 16'd1);
      wr(3'd6, 16'd4);
      wr(3'd7, 16'd8);
      pulse(1'b1, 1'b0, 1'b0);
      check("commit_done", {15'd0, bus.cfg_done}, 16'd1);
      check("commit_err", {15'd0, bus.cfg_err}, 16'd0);
      check("act_thsync", {8'd0, bus.Thsync}, 16'd4);
      check("act_thgdel", {8'd0, bus.Thgdel}, 16'd2);
      check("act_thgate", bus.Thgate, 16'd16);
      check("act_thlen", bus.Thlen, 16'd24);
      check("act_tvsync", {8'd0, bus.Tvsync}, 16'd1);
      check("act_tvgdel", {8'd0, bus.Tvgdel}, 16'd1);
      check("act_tvgate", bus.Tvgate, 16'd4);
      check("act_tvlen", bus.Tvlen, 16'd8);
      check("commit_stop_running", {15'd0, bus.running}, 16'd0);

      pulse(1'b0, 1'b1, 1'b0);
      check("start_running", {15'd0, bus.running}, 16'd1);
      check("start_tg_rst_n", {15'd0, bus.tg_rst_n}, 16'd1);
      check("start_clk_ena", {15'd0, bus.tg_clk_ena}, 16'd1);
      bus.pix_ena = 1'b0;
      #1;
      check("clk_ena_follows_pix", {15'd0, bus.tg_clk_ena}, 16'd0);
      bus.pix_ena = 1'b1;

      // Invalid commit while running: 4+2+16 = 22 >= 20.
      wr(3'd3, 16'd20);
      pulse(1'b1, 1'b0, 1'b0);
      check("inv_err", {15'd0, bus.cfg_err}, 16'd1);
      check("inv_done", {15'd0, bus.cfg_done}, 16'd0);
      check("inv_thlen", bus.Thlen, 16'd24);
      check("inv_busy", {15'd0, bus.busy}, 16'd0);
      check("inv_running", {15'd0, bus.running}, 16'd1);

      // Mid-frame change waits for the frame boundary.
      wr(3'd2, 16'd12);
      wr(3'd3, 16'd24);
      pulse(1'b1, 1'b0, 1'b0);
      check("pend_busy", {15'd0, bus.busy}, 16'd1);
      check("pend_thgate_old", bus.Thgate, 16'd16);
      wr(3'd0, 16'd9);
      pulse(1'b1, 1'b0, 1'b0);
      check("pend_recommit_quiet", {15'd0, bus.cfg_done | bus.cfg_err}, 16'd0);
      bus.pix_ena = 1'b0;
      eof();
      bus.pix_ena = 1'b1;
      check("pend_noena_thgate", bus.Thgate, 16'd16);
      check("pend_noena_busy", {15'd0, bus.busy}, 16'd1);
      eof();
      check("fb_thgate_new", bus.Thgate, 16'd12);
      check("fb_done", {15'd0, bus.cfg_done}, 16'd1);
      check("fb_thsync_dropped", {8'd0, bus.Thsync}, 16'd4);
      check("fb_busy", {15'd0, bus.busy}, 16'd0);
      check("fb_running", {15'd0, bus.running}, 16'd1);

      // Commit and stop together: load at the boundary, then stop.
      wr(3'd2, 16'd10);
      pulse(1'b1, 1'b0, 1'b1);
      check("cs_busy", {15'd0, bus.busy}, 16'd1);
      check("cs_running", {15'd0, bus.running}, 16'd1);
      tick();
      check("cs_thgate_wait", bus.Thgate, 16'd10 ^ 16'd6);
      eof();
      check("cs_thgate_new", bus.Thgate, 16'd10);
      check("cs_done", {15'd0, bus.cfg_done}, 16'd1);
      check("cs_tg_rst_n", {15'd0, bus.tg_rst_n}, 16'd0);
      check("cs_running", {15'd0, bus.running}, 16'd0);
      check("cs_busy_clr", {15'd0, bus.busy}, 16'd0);

      // Start and stop together in STOP: stop wins.
      pulse(1'b0, 1'b1, 1'b1);
      check("ss_running", {15'd0, bus.running}, 16'd0);
      check("ss_err", {15'd0, bus.cfg_err}, 16'd0);

      // Drain: commit rejected, stop only at the boundary.
      pulse(1'b0, 1'b1, 1'b0);
      check("drain_start", {15'd0, bus.running}, 16'd1);
      pulse(1'b0, 1'b0, 1'b1);
      check("drain_busy", {15'd0, bus.busy}, 16'd1);
      pulse(1'b1, 1'b0, 1'b0);
      check("drain_commit_err", {15'd0, bus.cfg_err}, 16'd1);
      check("drain_still_running", {15'd0, bus.running}, 16'd1);
      eof();
      check("drain_stopped", {15'd0, bus.running}, 16'd0);
      check("drain_busy_clr", {15'd0, bus.busy}, 16'd0);

      // Asynchronous reset mid-frame.
      pulse(1'b0, 1'b1, 1'b0);
      check("ar_running_pre", {15'd0, bus.running}, 16'd1);
      #2;
      rst = 1'b1;
      #1;
      check("ar_running", {15'd0, bus.running}, 16'd0);
      check("ar_clk_ena", {15'd0, bus.tg_clk_ena}, 16'd0);
      check("ar_tg_rst_n", {15'd0, bus.tg_rst_n}, 16'd0);
      check("ar_thgate", bus.Thgate, 16'd0);
      tick();
      rst = 1'b0;
      tick();
      pulse(1'b0, 1'b1, 1'b0);
      check("ar_start_err", {15'd0, bus.cfg_err}, 16'd1);
      check("ar_start_running", {15'd0, bus.running}, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
